// File: rtl/cfu_pkg.sv
// ---------------------------------------------------------------------------
// cfu_pkg
//   Shared types for the custom-function-unit issue path.
//   cfuop_t          : decoded CFU operation code; CFU_NOP marks a non-CFU instr
//   cfu_ctrl_state_t : issue controller states
//   is_cfu_op()      : true when a decoded op selects the CFU
// ---------------------------------------------------------------------------
package cfu_pkg;

  typedef logic [2:0] cfuop_t;

  localparam cfuop_t CFU_NOP = 3'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } cfu_ctrl_state_t;

  function automatic logic is_cfu_op(input cfuop_t op);
    return op != CFU_NOP;
  endfunction

endpackage

// File: rtl/cfu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// cfu_issue_ctrl
//   Issues a CFU op captured from the EX slot to the external CFU over a
//   valid/ready command channel, waits for the valid/ready response, and
//   returns the result to writeback as a one-cycle strobe. The pipeline is
//   stalled while the op is in flight. Flushed ops are dropped or drained;
//   a CFU that never answers is aborted after TIMEOUT wait cycles.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no op in flight; stale responses are accepted and discarded
//   ISSUE | command presented to the CFU, waiting for cmd_ready_i
//   WAIT  | command accepted, waiting for the response (timeout running)
//   DONE  | result strobed to writeback for one cycle
//   DRAIN | op flushed after the CFU took it; swallow its response
//
// Ports
//   clk, arst_n                        clock, async active-low reset
//   id_valid_i, id_cfuop_i,
//   id_opr_a_i, id_opr_b_i, id_rd_i    instruction in the EX slot
//   flush_i                            pipeline redirect
//   stall_o                            hold IF/ID/EX
//   cmd_valid_o/cmd_ready_i,
//   cmd_op_o, cmd_a_o, cmd_b_o         command channel to the CFU
//   rsp_valid_i/rsp_ready_o,
//   rsp_data_i                         response channel from the CFU
//   wb_valid_o, wb_rd_o, wb_data_o     writeback result
//   err_o                              pulse when a WAIT times out
// ---------------------------------------------------------------------------
module cfu_issue_ctrl
  import cfu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            id_valid_i,
  input  cfuop_t          id_cfuop_i,
  input  logic [XLEN-1:0] id_opr_a_i,
  input  logic [XLEN-1:0] id_opr_b_i,
  input  logic [4:0]      id_rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output cfuop_t          cmd_op_o,
  output logic [XLEN-1:0] cmd_a_o,
  output logic [XLEN-1:0] cmd_b_o,
  input  logic            rsp_valid_i,
  output logic            rsp_ready_o,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT);

  cfu_ctrl_state_t  r_state;
  logic [CNT_W-1:0] r_tmr;
  logic             r_cmd_valid;
  logic             r_rsp_ready;
  logic             r_wb_valid;
  cfuop_t           r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_data;

  logic             w_is_cfu;
  logic             w_start;
  logic             w_tmr_tc;
  logic [CNT_W-1:0] w_tmr_nxt;

  assign w_is_cfu = id_valid_i & is_cfu_op(id_cfuop_i);
  assign w_start  = w_is_cfu & ~flush_i;

  // Down-counter loaded with TIMEOUT at issue; remaining == 0 is the same
  // point as "TIMEOUT cycles elapsed". It holds at 0 instead of wrapping.
  assign w_tmr_tc  = (r_tmr == '0);
  assign w_tmr_nxt = w_tmr_tc ? r_tmr : r_tmr - CNT_W'(1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_tmr       <= '0;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_op        <= CFU_NOP;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_data      <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_rsp_ready <= 1'b1;
          if (w_start) begin
            r_op        <= id_cfuop_i;
            r_a         <= id_opr_a_i;
            r_b         <= id_opr_b_i;
            r_rd        <= id_rd_i;
            r_tmr       <= TMR_LOAD;
            r_cmd_valid <= 1'b1;
            r_rsp_ready <= 1'b0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            // CFU owns the op now; a flush must still absorb its response.
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_state     <= flush_i ? DRAIN : WAIT;
          end else if (flush_i) begin
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        WAIT: begin
          r_tmr <= w_tmr_nxt;
          if (flush_i) begin
            // A response arriving with the flush is consumed right here.
            r_state <= rsp_valid_i ? IDLE : DRAIN;
          end else if (rsp_valid_i) begin
            r_data      <= rsp_data_i;
            r_wb_valid  <= 1'b1;
            r_rsp_ready <= 1'b0;
            r_state     <= DONE;
          end else if (w_tmr_tc) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_rsp_ready <= 1'b1;
          r_state     <= IDLE;
        end
        DRAIN: begin
          r_tmr <= w_tmr_nxt;
          if (rsp_valid_i || w_tmr_tc) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_cmd_valid <= 1'b0;
          r_rsp_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // stall_o and err_o depend on same-cycle inputs: the stall must cover the
  // start cycle itself, and the abort is flagged in the final WAIT cycle.
  assign stall_o = ((r_state == IDLE) & w_start) |
                   (r_state == ISSUE) |
                   (r_state == WAIT) |
                   ((r_state == DRAIN) & w_is_cfu);

  assign err_o = (r_state == WAIT) & w_tmr_tc & ~rsp_valid_i & ~flush_i;

  assign cmd_valid_o = r_cmd_valid;
  assign cmd_op_o    = r_op;
  assign cmd_a_o     = r_a;
  assign cmd_b_o     = r_b;
  assign rsp_ready_o = r_rsp_ready;
  assign wb_valid_o  = r_wb_valid;
  assign wb_rd_o     = r_rd;
  assign wb_data_o   = r_data;

endmodule

// File: tb/tb_cfu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cfu_issue_ctrl
//   Scoreboard bench for cfu_issue_ctrl. A cycle-scripted driver plays the
//   pipeline and the CFU; for each op it pushes the expected command and the
//   expected writeback / error event (with the cycle it must appear in).
//   A monitor on the falling edge pops and compares whenever the DUT shows
//   a command, a writeback or an error, and checks the stall each cycle.
// ---------------------------------------------------------------------------
module tb_cfu_issue_ctrl;
  import cfu_pkg::*;

  localparam int XLEN   = 32;
  localparam int TO     = 8;
  localparam int CNT_W  = 4;
  localparam int N_RAND = 40;

  localparam int M_NORM = 0;  // normal completion after r/d delays
  localparam int M_TMO  = 1;  // CFU never answers
  localparam int M_IFL  = 2;  // flush in ISSUE while cmd_ready low
  localparam int M_WFL  = 3;  // flush after CFU took the command

  typedef struct {
    cfuop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          mode;
    int          r;        // ISSUE cycles with cmd_ready low
    int          d;        // WAIT cycles before the response
    int          f;        // WAIT index of flush (-1: flush on the ISSUE handshake)
    int          g;        // DRAIN index of response (-1: with the flush, -2: never)
    bit          preload;  // present the next CFU op during DRAIN
  } op_t;

  typedef struct {
    cfuop_t      op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  logic            clk;
  logic            arst_n;
  logic            id_valid_i;
  cfuop_t          id_cfuop_i;
  logic [XLEN-1:0] id_opr_a_i;
  logic [XLEN-1:0] id_opr_b_i;
  logic [4:0]      id_rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
  cfuop_t          cmd_op_o;
  logic [XLEN-1:0] cmd_a_o;
  logic [XLEN-1:0] cmd_b_o;
  logic            rsp_valid_i;
  logic            rsp_ready_o;
  logic [XLEN-1:0] rsp_data_i;
  logic            wb_valid_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            err_o;

  cfu_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .id_valid_i  (id_valid_i),
    .id_cfuop_i  (id_cfuop_i),
    .id_opr_a_i  (id_opr_a_i),
    .id_opr_b_i  (id_opr_b_i),
    .id_rd_i     (id_rd_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_op_o    (cmd_op_o),
    .cmd_a_o     (cmd_a_o),
    .cmd_b_o     (cmd_b_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_data_i  (rsp_data_i),
    .wb_valid_o  (wb_valid_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .err_o       (err_o)
  );

  cmd_t cmd_q[$];
  ev_t  ev_q[$];
  cmd_t hs;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_stall = 1'b0;
  op_t  ops[N_RAND];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The CFU's behaviour: result is a pure function of the command.
  function automatic logic [31:0] cfu_fn(input cfuop_t op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd1:    return a * b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      default: return a - b + 32'(op);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input cfuop_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    id_valid_i = v;
    id_cfuop_i = op;
    id_opr_a_i = a;
    id_opr_b_i = b;
    id_rd_i    = rd;
  endtask

  function automatic op_t mk(input cfuop_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int mode, input int r,
                             input int d, input int f, input int g);
    op_t s;
    s.op = op; s.a = a; s.b = b; s.rd = rd; s.mode = mode;
    s.r = r; s.d = d; s.f = f; s.g = g; s.preload = 1'b0;
    return s;
  endfunction

  // Monitor: compare whatever the DUT presents against the head of the queues.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("stall", 64'(stall_o), 64'(exp_stall));
      if (cmd_valid_o) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd_valid", 64'(cmd_valid_o), 64'd0);
        end else begin
          chk("cmd_op", 64'(cmd_op_o), 64'(cmd_q[0].op));
          chk("cmd_a",  64'(cmd_a_o),  64'(cmd_q[0].a));
          chk("cmd_b",  64'(cmd_b_o),  64'(cmd_q[0].b));
          if (cmd_ready_i) begin
            hs.op = cmd_op_o; hs.a = cmd_a_o; hs.b = cmd_b_o;
            void'(cmd_q.pop_front());
          end else if (flush_i) begin
            void'(cmd_q.pop_front());
          end
        end
      end
      if (wb_valid_o || err_o) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_wb_or_err", 64'({wb_valid_o, err_o}), 64'd0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("event_kind",  64'({wb_valid_o, err_o}), e.is_err ? 64'd1 : 64'd2);
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          if (!e.is_err) begin
            chk("wb_rd",   64'(wb_rd_o),   64'(e.rd));
            chk("wb_data", 64'(wb_data_o), 64'(e.data));
          end
        end
      end
    end
  end

  // Idle cycle with harmless noise: stray responses, NOP instrs, flushed CFU ops.
  task automatic gap_cycle();
    int sel;
    step();
    exp_stall   = 1'b0;
    cmd_ready_i = 1'($urandom_range(0, 1));
    rsp_valid_i = 1'($urandom_range(0, 1));
    rsp_data_i  = $urandom;
    sel = int'($urandom_range(0, 2));
    if (sel == 0) begin
      drive_id(1'b0, CFU_NOP, 32'd0, 32'd0, 5'd0);
      flush_i = 1'b0;
    end else if (sel == 1) begin
      drive_id(1'b1, CFU_NOP, $urandom, $urandom, 5'($urandom));
      flush_i = 1'($urandom_range(0, 1));
    end else begin
      drive_id(1'b1, cfuop_t'($urandom_range(1, 7)), $urandom, $urandom, 5'($urandom));
      flush_i = 1'b1;
    end
  endtask

  task automatic run_op(input op_t s, input op_t nxt);
    int t;
    int n_wait;
    int n_drain;
    bit issue_flush_hs;
    issue_flush_hs = (s.mode == M_WFL) && (s.f < 0);
    step();
    t = cyc;
    drive_id(1'b1, s.op, s.a, s.b, s.rd);
    flush_i = 1'b0; cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = $urandom;
    exp_stall = 1'b1;
    cmd_q.push_back('{s.op, s.a, s.b});
    if (s.mode == M_NORM) ev_q.push_back('{1'b0, t + 3 + s.r + s.d, s.rd, cfu_fn(s.op, s.a, s.b)});
    if (s.mode == M_TMO)  ev_q.push_back('{1'b1, t + 2 + s.r + TO, 5'd0, 32'd0});
    for (int k = 0; k <= s.r; k++) begin
      step();
      exp_stall   = 1'b1;
      rsp_data_i  = $urandom;
      cmd_ready_i = (k == s.r) && (s.mode != M_IFL);
      flush_i     = (k == s.r) && ((s.mode == M_IFL) || issue_flush_hs);
    end
    if (s.mode == M_IFL) return;
    if (!issue_flush_hs) begin
      n_wait = (s.mode == M_NORM) ? s.d : (s.mode == M_TMO) ? TO : s.f;
      for (int k = 0; k <= n_wait; k++) begin
        step();
        exp_stall   = 1'b1;
        cmd_ready_i = 1'b0;
        flush_i     = (s.mode == M_WFL) && (k == n_wait);
        rsp_valid_i = (k == n_wait) && ((s.mode == M_NORM) || (s.mode == M_WFL && s.g == -1));
        rsp_data_i  = rsp_valid_i ? cfu_fn(hs.op, hs.a, hs.b) : $urandom;
      end
    end
    if (s.mode == M_NORM) begin
      step();
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
      exp_stall   = 1'b0;
      return;
    end
    if (s.mode == M_TMO || s.g == -1) return;
    // Drain length: up to the response, or until TIMEOUT cycles have elapsed
    // since the command was accepted.
    n_drain = (s.g >= 0) ? s.g + 1 : TO - s.f;
    for (int k = 0; k < n_drain; k++) begin
      step();
      flush_i     = 1'b0;
      cmd_ready_i = 1'b0;
      rsp_valid_i = (s.g >= 0) && (k == s.g);
      rsp_data_i  = $urandom;
      if (s.preload) drive_id(1'b1, nxt.op, nxt.a, nxt.b, nxt.rd);
      else           drive_id(1'b0, CFU_NOP, 32'd0, 32'd0, 5'd0);
      exp_stall = s.preload;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    op_t dummy;
    op_t s;
    int  m;
    dummy = mk(3'd1, 32'd0, 32'd0, 5'd0, M_NORM, 0, 0, 0, 0);

    arst_n = 1'b0;
    drive_id(1'b0, CFU_NOP, 32'd0, 32'd0, 5'd0);
    flush_i = 1'b0; cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    chk("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    chk("rst_wb_valid",  64'(wb_valid_o),  64'd0);
    chk("rst_err",       64'(err_o),       64'd0);
    chk("rst_stall",     64'(stall_o),     64'd0);
    chk("rst_cmd_op",    64'(cmd_op_o),    64'(CFU_NOP));
    chk("rst_cmd_a",     64'(cmd_a_o),     64'd0);
    chk("rst_wb_data",   64'(wb_data_o),   64'd0);
    #21;
    arst_n = 1'b1;

    // Minimum latency: 5 * 7 through op 1 gives 0x23 in DONE at T+3.
    run_op(mk(3'd1, 32'd5, 32'd7, 5'd9, M_NORM, 0, 0, 0, 0), dummy);
    gap_cycle();
    // Command held for 4 cycles with cmd_ready low.
    run_op(mk(3'd2, 32'hDEAD_0001, 32'h0000_BEEF, 5'd17, M_NORM, 4, 1, 0, 0), dummy);
    // Response exactly on the last legal WAIT cycle.
    run_op(mk(3'd3, 32'h1234_5678, 32'h0F0F_0F0F, 5'd1, M_NORM, 0, TO, 0, 0), dummy);
    // No response: abort with err on the (TO+1)th WAIT cycle.
    run_op(mk(3'd4, 32'd11, 32'd22, 5'd5, M_TMO, 0, 0, 0, 0), dummy);
    // Flush in WAIT, response three cycles after the flush, then a normal op.
    run_op(mk(3'd5, 32'd3, 32'd4, 5'd6, M_WFL, 0, 0, 1, 2), dummy);
    run_op(mk(3'd2, 32'd100, 32'd23, 5'd31, M_NORM, 1, 2, 0, 0), dummy);
    // Flush in ISSUE with cmd_ready low: command withdrawn.
    run_op(mk(3'd6, 32'd8, 32'd9, 5'd2, M_IFL, 0, 0, 0, 0), dummy);
    gap_cycle();
    // Flush together with the handshake, then DRAIN runs to its timeout.
    run_op(mk(3'd7, 32'd1, 32'd2, 5'd3, M_WFL, 1, 0, -1, -2), dummy);
    // Flush on the same cycle as the response.
    run_op(mk(3'd1, 32'd6, 32'd6, 5'd4, M_WFL, 0, 0, 2, -1), dummy);

    // Reset in WAIT, then stray responses must be discarded.
    step();
    drive_id(1'b1, 3'd2, 32'hA5A5_0000, 32'h0000_5A5A, 5'd12);
    flush_i = 1'b0; cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; exp_stall = 1'b1;
    cmd_q.push_back('{3'd2, 32'hA5A5_0000, 32'h0000_5A5A});
    step(); cmd_ready_i = 1'b1;
    step(); cmd_ready_i = 1'b0;
    step();
    #2;
    arst_n = 1'b0;
    drive_id(1'b0, CFU_NOP, 32'd0, 32'd0, 5'd0);
    exp_stall = 1'b0;
    #1;
    chk("midrst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    chk("midrst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    chk("midrst_wb_valid",  64'(wb_valid_o),  64'd0);
    chk("midrst_err",       64'(err_o),       64'd0);
    chk("midrst_stall",     64'(stall_o),     64'd0);
    chk("midrst_cmd_op",    64'(cmd_op_o),    64'(CFU_NOP));
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      rsp_valid_i = 1'b1;
      rsp_data_i  = $urandom;
      exp_stall   = 1'b0;
      chk("postrst_rsp_ready", 64'(rsp_ready_o), 64'd1);
    end
    step();
    rsp_valid_i = 1'b0;
    run_op(mk(3'd1, 32'd12, 32'd12, 5'd20, M_NORM, 2, 3, 0, 0), dummy);

    // Randomized ops.
    for (int i = 0; i < N_RAND; i++) begin
      s.op = cfuop_t'($urandom_range(1, 7));
      s.a  = $urandom;
      s.b  = $urandom;
      s.rd = 5'($urandom);
      m = int'($urandom_range(0, 9));
      s.mode = (m < 4) ? M_NORM : (m < 5) ? M_TMO : (m < 6) ? M_IFL : M_WFL;
      s.r = int'($urandom_range(0, 3));
      s.d = int'($urandom_range(0, TO));
      s.f = int'($urandom_range(0, 4)) - 1;
      if (s.f < 0) s.g = ($urandom_range(0, 3) == 0) ? -2 : int'($urandom_range(0, 3));
      else         s.g = int'($urandom_range(0, 5)) - 2;
      s.preload = 1'b0;
      ops[i] = s;
    end
    for (int i = 0; i + 1 < N_RAND; i++) begin
      if (ops[i].mode == M_WFL && ops[i].g != -1 && $urandom_range(0, 1) == 1)
        ops[i].preload = 1'b1;
    end
    for (int i = 0; i < N_RAND; i++) begin
      run_op(ops[i], (i + 1 < N_RAND) ? ops[i + 1] : dummy);
      if (!ops[i].preload) begin
        m = int'($urandom_range(0, 3));
        for (int k = 0; k < m; k++) gap_cycle();
      end
    end

    for (int k = 0; k < 5; k++) gap_cycle();
    step();
    chk("pending_events", 64'(ev_q.size()), 64'd0);
    chk("pending_cmds",   64'(cmd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
